// File: rtl/ecm_ddr_wr_ctrl.sv
// ecm_ddr_wr_ctrl
//   Buffers complete ECM packets from the 16-to-128 packer in a two-entry
//   ping-pong RAM. The packer only presents the destination address on the
//   last word, so a packet is held until its tag arrives. The packet is then
//   issued as one DDR3 write command followed by its data burst.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pkt_i_data/val/eof  packed 128-bit words from the packer (no backpressure)
//   pkt_i_addr          {1'b0, len[4:0], index[9:0]}, valid with eof
//   cmd_val/rdy         DDR write command handshake
//   cmd_addr, cmd_len   BASE_ADDR + {index, 5'b0}, words-1
//   wd_val/rdy          DDR write data handshake
//   wd_data, wd_last    write data word, last beat of the burst
//   drop_err, len_err   sticky error flags
//   pkt_wr_cnt          packets written (statistics build only, else 0)
//   pkt_drop_cnt        packets dropped (statistics build only, else 0)
//
// Build option
//   ECM_WR_STAT_EN      when defined, builds the two 16-bit statistic counters
module ecm_ddr_wr_ctrl #(
  parameter int                DDR_AW    = 28,
  parameter logic [DDR_AW-1:0] BASE_ADDR = 28'h0000000,
  parameter int                MAX_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [127:0]      pkt_i_data,
  input  logic              pkt_i_val,
  input  logic              pkt_i_eof,
  input  logic [15:0]       pkt_i_addr,
  output logic              cmd_val,
  input  logic              cmd_rdy,
  output logic [DDR_AW-1:0] cmd_addr,
  output logic [4:0]        cmd_len,
  output logic              wd_val,
  input  logic              wd_rdy,
  output logic [127:0]      wd_data,
  output logic              wd_last,
  output logic              drop_err,
  output logic              len_err,
  output logic [15:0]       pkt_wr_cnt,
  output logic [15:0]       pkt_drop_cnt
);

  localparam int         BW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [4:0] LAST_IDX = 5'(MAX_WORDS - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CMD, R_DATA}  r_state_t;

  // Two buffers share one array; the MSB of the address selects the buffer.
  logic [127:0] mem [2*MAX_WORDS];

  w_state_t   w_state, w_next;
  logic       wr_sel;
  logic [4:0] wcnt, wcnt_nxt;
  logic [1:0] full;
  logic [9:0] desc_idx [2];
  logic [4:0] desc_len [2];
  logic       mem_we, commit, drop_now, buf_free;

  r_state_t   r_state, r_next;
  logic       rd_sel;
  logic [5:0] rptr;
  logic       cmd_load, fetch, rel;

  logic unused_addr_msb;
  assign unused_addr_msb = pkt_i_addr[15];

  // A buffer being released this cycle can take the first word of a new packet.
  assign buf_free = !full[wr_sel] || (rel && (rd_sel == wr_sel));

  always_comb begin
    w_next   = w_state;
    wcnt_nxt = wcnt;
    mem_we   = 1'b0;
    commit   = 1'b0;
    drop_now = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (pkt_i_val) begin
          if (buf_free) begin
            mem_we = 1'b1;
            if (pkt_i_eof) begin
              commit = 1'b1;
            end else begin
              w_next   = W_FILL;
              wcnt_nxt = 5'd1;
            end
          end else begin
            drop_now = 1'b1;
            if (!pkt_i_eof) w_next = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (pkt_i_val) begin
          if (pkt_i_eof) begin
            mem_we   = 1'b1;
            commit   = 1'b1;
            w_next   = W_IDLE;
            wcnt_nxt = 5'd0;
          end else if (wcnt == LAST_IDX) begin
            // Buffer is full and the packet keeps going: abandon it unwritten.
            drop_now = 1'b1;
            w_next   = W_DROP;
            wcnt_nxt = 5'd0;
          end else begin
            mem_we   = 1'b1;
            wcnt_nxt = wcnt + 5'd1;
          end
        end
      end
      W_DROP: begin
        if (pkt_i_val && pkt_i_eof) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      wr_sel      <= 1'b0;
      wcnt        <= 5'd0;
      full        <= 2'b00;
      desc_idx[0] <= '0;
      desc_idx[1] <= '0;
      desc_len[0] <= '0;
      desc_len[1] <= '0;
      drop_err    <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      w_state <= w_next;
      wcnt    <= wcnt_nxt;
      if (drop_now) drop_err <= 1'b1;
      if (commit) begin
        desc_idx[wr_sel] <= pkt_i_addr[9:0];
        desc_len[wr_sel] <= wcnt;
        wr_sel           <= ~wr_sel;
        if (pkt_i_addr[14:10] != wcnt) len_err <= 1'b1;
      end
      // Set after clear so a same-cycle release and refill leaves it full.
      if (rel)    full[rd_sel] <= 1'b0;
      if (commit) full[wr_sel] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{wr_sel, wcnt[BW-1:0]}] <= pkt_i_data;
  end

  assign cmd_val = (r_state == R_CMD);

  always_comb begin
    r_next   = r_state;
    cmd_load = 1'b0;
    fetch    = 1'b0;
    rel      = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (full[rd_sel]) begin
          r_next   = R_CMD;
          cmd_load = 1'b1;
        end
      end
      R_CMD: begin
        if (cmd_rdy) r_next = R_DATA;
      end
      R_DATA: begin
        // Read the next word whenever the output slot is empty or draining,
        // so a continuously ready sink gets one word per cycle.
        fetch = (!wd_val || wd_rdy) && (rptr <= {1'b0, cmd_len});
        if (wd_val && wd_rdy && wd_last) begin
          rel    = 1'b1;
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // RAM read stage: wd_data is the RAM output register and only moves on fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      rd_sel   <= 1'b0;
      cmd_addr <= '0;
      cmd_len  <= '0;
      rptr     <= '0;
      wd_val   <= 1'b0;
      wd_last  <= 1'b0;
      wd_data  <= '0;
    end else begin
      r_state <= r_next;
      if (cmd_load) begin
        cmd_addr <= BASE_ADDR + DDR_AW'({desc_idx[rd_sel], 5'b0});
        cmd_len  <= desc_len[rd_sel];
        rptr     <= '0;
      end
      if (fetch) begin
        wd_data <= mem[{rd_sel, rptr[BW-1:0]}];
        wd_val  <= 1'b1;
        wd_last <= (rptr == {1'b0, cmd_len});
        rptr    <= rptr + 6'd1;
      end else if (wd_val && wd_rdy) begin
        wd_val  <= 1'b0;
        wd_last <= 1'b0;
      end
      if (rel) rd_sel <= ~rd_sel;
    end
  end

`ifdef ECM_WR_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_wr_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (rel)      pkt_wr_cnt   <= pkt_wr_cnt + 16'd1;
      if (drop_now) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
    end
  end
`else
  assign pkt_wr_cnt   = '0;
  assign pkt_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ecm_ddr_wr_ctrl.sv
`timescale 1ns/1ps
module tb_ecm_ddr_wr_ctrl;
  localparam logic [27:0] BASE = 28'hFFFFF00;
  localparam int          MAXW = 32;
`ifdef ECM_WR_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic         clk, rst_n;
  logic [127:0] pkt_i_data;
  logic         pkt_i_val, pkt_i_eof;
  logic [15:0]  pkt_i_addr;
  logic         cmd_val, cmd_rdy;
  logic [27:0]  cmd_addr;
  logic [4:0]   cmd_len;
  logic         wd_val, wd_rdy, wd_last;
  logic [127:0] wd_data;
  logic         drop_err, len_err;
  logic [15:0]  pkt_wr_cnt, pkt_drop_cnt;

  int tests = 0;
  int fails = 0;

  // Observed handshakes
  logic [127:0] wd_q[$];
  logic         wl_q[$];
  logic [27:0]  ca_q[$];
  logic [4:0]   cl_q[$];
  longint       hs_cyc[$];
  longint       cyc;

  // Reference model state
  logic [127:0] exp_words[$];
  logic         exp_last[$];
  logic [27:0]  exp_addr[$];
  logic [4:0]   exp_len[$];
  int           model_occ, model_wr, model_drop;
  logic         exp_drop_err, exp_len_err;
  int           rdy_mode;

  ecm_ddr_wr_ctrl #(.DDR_AW(28), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_i_data(pkt_i_data), .pkt_i_val(pkt_i_val), .pkt_i_eof(pkt_i_eof),
    .pkt_i_addr(pkt_i_addr),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_val(wd_val), .wd_rdy(wd_rdy), .wd_data(wd_data), .wd_last(wd_last),
    .drop_err(drop_err), .len_err(len_err),
    .pkt_wr_cnt(pkt_wr_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] model_addr(input logic [9:0] idx);
    return BASE + 28'(idx) * 28'd32;
  endfunction

  // Sink ready pattern: 0 always ready, 1 alternating, 2 random
  initial begin : rdy_driver
    wd_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       wd_rdy = 1'b1;
        1:       wd_rdy = ~wd_rdy;
        default: wd_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    logic         hold;
    logic [127:0] hd;
    logic         hl;
    hold = 1'b0; hd = '0; hl = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("wd_hold_val",  128'(wd_val),  128'(1'b1));
          check("wd_hold_data", wd_data,       hd);
          check("wd_hold_last", 128'(wd_last), 128'(hl));
        end
        if (cmd_val && cmd_rdy) begin
          ca_q.push_back(cmd_addr);
          cl_q.push_back(cmd_len);
        end
        if (wd_val && wd_rdy) begin
          wd_q.push_back(wd_data);
          wl_q.push_back(wd_last);
          hs_cyc.push_back(cyc);
        end
        hold = wd_val && !wd_rdy;
        hd   = wd_data;
        hl   = wd_last;
      end
    end
  end

  // Called and returns at #1 after a rising edge.
  task automatic send_pkt(input int n, input logic [9:0] idx, input logic [4:0] tlen, input bit gaps);
    logic [127:0] w[$];
    bit           acc;
    for (int i = 0; i < n; i++) begin
      logic [127:0] d;
      if (gaps && $urandom_range(0, 3) == 0) begin
        pkt_i_val = 1'b0; pkt_i_eof = 1'b0;
        @(posedge clk); #1;
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      pkt_i_data = d;
      pkt_i_val  = 1'b1;
      pkt_i_eof  = (i == n - 1);
      pkt_i_addr = (i == n - 1) ? {1'b0, tlen, idx} : 16'($urandom);
      w.push_back(d);
      @(posedge clk); #1;
    end
    pkt_i_val = 1'b0;
    pkt_i_eof = 1'b0;
    acc = (n <= MAXW) && (model_occ < 2);
    if (acc) begin
      model_occ++;
      exp_addr.push_back(model_addr(idx));
      exp_len.push_back(5'(n - 1));
      for (int i = 0; i < n; i++) begin
        exp_words.push_back(w[i]);
        exp_last.push_back(i == n - 1);
      end
      if (tlen != 5'(n - 1)) exp_len_err = 1'b1;
    end else begin
      exp_drop_err = 1'b1;
      model_drop++;
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    int ncmd;
    guard = 0;
    while (wd_q.size() < exp_words.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    ncmd = exp_addr.size();
    check({tag, "_beats"}, 128'(wd_q.size()), 128'(exp_words.size()));
    check({tag, "_cmds"},  128'(ca_q.size()), 128'(exp_addr.size()));
    while (exp_addr.size() > 0 && ca_q.size() > 0) begin
      check({tag, "_cmd_addr"}, 128'(ca_q.pop_front()), 128'(exp_addr.pop_front()));
      check({tag, "_cmd_len"},  128'(cl_q.pop_front()), 128'(exp_len.pop_front()));
    end
    while (exp_words.size() > 0 && wd_q.size() > 0) begin
      check({tag, "_wd_data"}, wd_q.pop_front(), exp_words.pop_front());
      check({tag, "_wd_last"}, 128'(wl_q.pop_front()), 128'(exp_last.pop_front()));
    end
    exp_addr.delete(); exp_len.delete(); exp_words.delete(); exp_last.delete();
    ca_q.delete(); cl_q.delete(); wd_q.delete(); wl_q.delete();
    model_wr  += ncmd;
    model_occ  = 0;
    check({tag, "_idle_cmd_val"}, 128'(cmd_val),  128'(1'b0));
    check({tag, "_idle_wd_val"},  128'(wd_val),   128'(1'b0));
    check({tag, "_drop_err"},     128'(drop_err), 128'(exp_drop_err));
    check({tag, "_len_err"},      128'(len_err),  128'(exp_len_err));
    check({tag, "_wr_cnt"},   128'(pkt_wr_cnt),   128'(STAT ? 16'(model_wr)   : 16'd0));
    check({tag, "_drop_cnt"}, 128'(pkt_drop_cnt), 128'(STAT ? 16'(model_drop) : 16'd0));
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd_val"},  128'(cmd_val),      '0);
    check({tag, "_cmd_addr"}, 128'(cmd_addr),     '0);
    check({tag, "_cmd_len"},  128'(cmd_len),      '0);
    check({tag, "_wd_val"},   128'(wd_val),       '0);
    check({tag, "_wd_data"},  wd_data,            '0);
    check({tag, "_wd_last"},  128'(wd_last),      '0);
    check({tag, "_drop_err"}, 128'(drop_err),     '0);
    check({tag, "_len_err"},  128'(len_err),      '0);
    check({tag, "_wr_cnt"},   128'(pkt_wr_cnt),   '0);
    check({tag, "_drop_cnt"}, 128'(pkt_drop_cnt), '0);
  endtask

  task automatic model_clear();
    exp_addr.delete(); exp_len.delete(); exp_words.delete(); exp_last.delete();
    ca_q.delete(); cl_q.delete(); wd_q.delete(); wl_q.delete(); hs_cyc.delete();
    model_occ = 0; model_wr = 0; model_drop = 0;
    exp_drop_err = 1'b0; exp_len_err = 1'b0;
  endtask

  initial begin : main
    longint span;
    int     guard;
    logic [9:0] idx;
    rst_n = 1'b0; pkt_i_data = '0; pkt_i_val = 1'b0; pkt_i_eof = 1'b0; pkt_i_addr = '0;
    cmd_rdy = 1'b1; rdy_mode = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 12-word packet, always-ready sink, command latency and address
    hs_cyc.delete();
    send_pkt(12, 10'h005, 5'd11, 1'b0);
    check("s1_cmd_val_t1", 128'(cmd_val), 128'(1'b0));
    @(posedge clk); #1;
    check("s1_cmd_val_t2", 128'(cmd_val), 128'(1'b1));
    check("s1_cmd_addr",   128'(cmd_addr), 128'(28'hFFFFFA0));
    check("s1_cmd_len",    128'(cmd_len),  128'(5'd11));
    drain("s1");
    span = (hs_cyc.size() == 12) ? hs_cyc[11] - hs_cyc[0] : -1;
    check("s1_back_to_back", 128'(span), 128'(11));

    // 24-word packet, alternating sink ready
    rdy_mode = 1;
    idx = 10'($urandom);
    send_pkt(24, idx, 5'd23, 1'b1);
    drain("s2");

    // tag length disagrees with counted words
    rdy_mode = 2;
    send_pkt(8, 10'h3FF, 5'd5, 1'b0);
    drain("s4");

    // command stalled while three packets arrive; third one is dropped
    cmd_rdy = 1'b0;
    send_pkt(6,  10'($urandom), 5'd5,  1'b1);
    send_pkt(17, 10'($urandom), 5'd16, 1'b1);
    send_pkt(3,  10'($urandom), 5'd2,  1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("s3_drop_err",    128'(drop_err), 128'(1'b1));
    check("s3_cmd_held",    128'(cmd_val),  128'(1'b1));
    check("s3_cmd_addr_p1", 128'(cmd_addr), 128'(exp_addr[0]));
    check("s3_cmd_len_p1",  128'(cmd_len),  128'(exp_len[0]));
    cmd_rdy = 1'b1;
    drain("s3");

    // overlength packet (33 words without eof, ended by a 34th), then a good one
    send_pkt(34, 10'($urandom), 5'd1, 1'b0);
    send_pkt(32, 10'($urandom), 5'd31, 1'b1);
    drain("s5");

    // reset in the middle of a burst
    send_pkt(16, 10'($urandom), 5'd15, 1'b0);
    guard = 0;
    while (wd_q.size() < 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("s6_burst_started", 128'(wd_q.size() >= 3), 128'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("s6_async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    send_pkt(10, 10'h2A1, 5'd9, 1'b1);
    drain("s6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
